// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and defaults for the HI/LO multiply-divide unit
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } mdu_state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring unsigned divider, one quotient bit per step
module mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // quo doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (start_i) begin
            cnt <= '0;
            quo <= dividend_i;
            rem <= '0;
            dvs <= divisor_i;
        end else if (step_i) begin
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= shifted[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
        end
    end

    assign quo_o  = quo;
    assign rem_o  = rem;
    assign last_o = (cnt == CW'(XLEN - 1));

endmodule

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO multiply-divide unit with pipelined multiply and iterative divide
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN    = MDU_XLEN,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              op_valid_i,
    input  mdu_op_t           op_i,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic              rd_hilo_i,
    output logic [2*XLEN-1:0] hilo_o,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o
);

    mdu_state_t        state;
    logic [3:0]        mul_cnt;
    logic [2*XLEN-1:0] mul_pipe [MUL_LAT];
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [2*XLEN-1:0] hilo_q;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              accept;
    logic              is_div;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic              div_start;
    logic              div_last;
    logic              neg_q;
    logic              neg_r;
    logic              div0;
    logic              busy_q;
    logic              done_q;

    always_comb begin
        accept    = (state == S_IDLE) && op_valid_i && !flush_i && (op_i != OP_NONE);
        is_div    = (op_i == OP_DIV) || (op_i == OP_DIVU);
        a_neg     = (op_i == OP_DIV) && src_a[XLEN-1];
        b_neg     = (op_i == OP_DIV) && src_b[XLEN-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
        b_zero    = (src_b == '0);
        div_start = accept && is_div && !b_zero;
        // a 2*XLEN-wide product of extended operands is exact for both signednesses
        mul_a     = (op_i == OP_MULT) ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
        mul_b     = (op_i == OP_MULT) ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
        mul_prod  = mul_a * mul_b;
        quo_fix   = neg_q ? -div_quo : div_quo;
        rem_fix   = neg_r ? -div_rem : div_rem;
    end

    mdu_div_iter #(
        .XLEN(XLEN)
    ) u_div_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .step_i     (state == S_DIV),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .last_o     (div_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
        end else begin
            if (accept) mul_pipe[0] <= mul_prod;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hilo_q  <= '0;
            mul_cnt <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            a_raw   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op_i)
                            OP_MTHI: hilo_q[2*XLEN-1:XLEN] <= src_a;
                            OP_MTLO: hilo_q[XLEN-1:0]      <= src_a;
                            OP_MULT, OP_MULTU: begin
                                state   <= S_MUL;
                                busy_q  <= 1'b1;
                                mul_cnt <= '0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state  <= b_zero ? S_FIX : S_DIV;
                                busy_q <= 1'b1;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                div0   <= b_zero;
                                a_raw  <= src_a;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    // a flush landing on the commit edge does not cancel the commit
                    if (mul_cnt == 4'(MUL_LAT - 1)) begin
                        hilo_q <= mul_pipe[MUL_LAT-1];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (flush_i) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt + 4'd1;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else if (div_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hilo_q <= div0 ? {a_raw, {XLEN{1'b1}}} : {rem_fix, quo_fix};
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign hilo_o  = hilo_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign stall_o = busy_q & (rd_hilo_i | (op_valid_i & (op_i != OP_NONE))) & ~flush_i;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - self-checking bench for hilo_mdu (XLEN=32, MUL_LAT=3)
module tb_hilo_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        op_valid_i;
    mdu_op_t     op_i;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_hilo_i;
    logic [63:0] hilo_o;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;

    hilo_mdu #(.XLEN(32), .MUL_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .src_a      (src_a),
        .src_b      (src_b),
        .rd_hilo_i  (rd_hilo_i),
        .hilo_o     (hilo_o),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        int          busy;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] model(input mdu_op_t op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] old);
        longint sa, sb, p, q, r;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT: begin
                p = sa * sb;
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            OP_MTHI: return {a, old[31:0]};
            OP_MTLO: return {old[63:32], a};
            default: return old;
        endcase
    endfunction

    function automatic int busy_len(input mdu_op_t op, input logic [31:0] b);
        if (op == OP_MULT || op == OP_MULTU) return 3;
        if (op == OP_DIV || op == OP_DIVU) return (b == 0) ? 1 : 33;
        return 0;
    endfunction

    task automatic start_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid_i = 1'b1;
        op_i       = op;
        src_a      = a;
        src_b      = b;
        @(negedge clk);
        op_valid_i = 1'b0;
        op_i       = OP_NONE;
    endtask

    task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [63:0] hilo, output int busy_n,
                          output logic done);
        start_op(op, a, b);
        busy_n = 0;
        while (busy_o && busy_n < 100) begin
            busy_n++;
            if (scramble) begin
                src_a = $urandom;
                src_b = $urandom;
            end
            @(negedge clk);
        end
        hilo = hilo_o;
        done = done_o;
    endtask

    vec_t        vecs [10];
    logic [63:0] got_hilo;
    logic [63:0] ref_hilo;
    logic [63:0] exp_hilo;
    logic        got_done;
    int          got_busy;
    mdu_op_t     rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        exp_stall;
    logic        seen_done;
    int          cyc;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,        64'hFFFF_FFFF_FFFF_FFFE, 3};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        64'h0000_0001_FFFF_FFFE, 3};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,        64'h0000_0002_0000_000E, 33};
        vecs[4] = '{OP_DIVU,  32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 1};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
        vecs[6] = '{OP_MTHI,  32'hAAAA_5555, 32'd9,        64'hAAAA_5555_8000_0000, 0};
        vecs[7] = '{OP_MTLO,  32'h1234_5678, 32'd9,        64'hAAAA_5555_1234_5678, 0};
        vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33};
        vecs[9] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 3};

        rst        = 1'b0;
        flush_i    = 1'b0;
        op_valid_i = 1'b0;
        op_i       = OP_NONE;
        src_a      = '0;
        src_b      = '0;
        rd_hilo_i  = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("reset_hilo", hilo_o, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        check("reset_done", {63'd0, done_o}, 64'd0);
        check("reset_stall", {63'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, got_hilo, got_busy, got_done);
            check($sformatf("vec%0d_hilo", i), got_hilo, vecs[i].hilo);
            check($sformatf("vec%0d_busy", i), 64'(got_busy), 64'(vecs[i].busy));
            check($sformatf("vec%0d_done", i), {63'd0, got_done}, {63'd0, vecs[i].busy != 0});
        end

        ref_hilo = vecs[9].hilo;
        for (int i = 0; i < 40; i++) begin
            rop = mdu_op_t'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            exp_hilo = model(rop, ra, rb, ref_hilo);
            run_op(rop, ra, rb, 1'b1, got_hilo, got_busy, got_done);
            check($sformatf("rand%0d_hilo", i), got_hilo, exp_hilo);
            check($sformatf("rand%0d_busy", i), 64'(got_busy), 64'(busy_len(rop, rb)));
            check($sformatf("rand%0d_done", i), {63'd0, got_done}, {63'd0, busy_len(rop, rb) != 0});
            ref_hilo = exp_hilo;
        end

        // flush on the multiply commit edge still commits
        start_op(OP_MULT, 32'd3, 32'd5);
        repeat (2) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_commit_done", {63'd0, done_o}, 64'd1);
        check("flush_commit_hilo", hilo_o, 64'd15);
        check("flush_commit_busy", {63'd0, busy_o}, 64'd0);

        // flush at divide cycle 10 aborts with no commit
        start_op(OP_DIV, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        flush_i   = 1'b1;
        rd_hilo_i = 1'b1;
        #1;
        check("flush_masks_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        flush_i   = 1'b0;
        rd_hilo_i = 1'b0;
        check("flush_busy", {63'd0, busy_o}, 64'd0);
        check("flush_done", {63'd0, done_o}, 64'd0);
        check("flush_hilo", hilo_o, 64'd15);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("flush_no_late_done", {63'd0, seen_done}, 64'd0);
        check("flush_hilo_late", hilo_o, 64'd15);

        // flush beats a simultaneous acceptance
        @(negedge clk);
        op_valid_i = 1'b1;
        op_i       = OP_MULT;
        src_a      = 32'd4;
        src_b      = 32'd4;
        flush_i    = 1'b1;
        @(negedge clk);
        op_valid_i = 1'b0;
        op_i       = OP_NONE;
        flush_i    = 1'b0;
        check("flush_accept_busy", {63'd0, busy_o}, 64'd0);
        repeat (4) @(negedge clk);
        check("flush_accept_hilo", hilo_o, 64'd15);

        // stall while a divide is in flight
        start_op(OP_DIV, 32'd1000, 32'd7);
        cyc = 0;
        while (busy_o && cyc < 60) begin
            rd_hilo_i  = (cyc % 3 == 0);
            op_valid_i = (cyc % 3 == 1);
            op_i       = (cyc % 3 == 1) ? OP_MULT : OP_NONE;
            exp_stall  = (cyc % 3 != 2);
            #1;
            check($sformatf("stall_c%0d", cyc), {63'd0, stall_o}, {63'd0, exp_stall});
            cyc++;
            @(negedge clk);
        end
        rd_hilo_i  = 1'b0;
        op_valid_i = 1'b0;
        op_i       = OP_NONE;
        check("stall_busy_len", 64'(cyc), 64'd33);
        check("stall_div_hilo", hilo_o, {32'd6, 32'd142});
        check("stall_div_done", {63'd0, done_o}, 64'd1);
        #1;
        check("stall_idle", {63'd0, stall_o}, 64'd0);

        // asynchronous reset mid-divide
        start_op(OP_DIV, 32'd50, 32'd3);
        repeat (4) @(negedge clk);
        rd_hilo_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_hilo", hilo_o, 64'd0);
        check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        check("rst_mid_stall", {63'd0, stall_o}, 64'd0);
        check("rst_mid_done", {63'd0, done_o}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        rd_hilo_i = 1'b0;
        run_op(OP_MTHI, 32'h0000_1234, 32'd0, 1'b0, got_hilo, got_busy, got_done);
        check("mthi_after_rst", got_hilo, 64'h0000_1234_0000_0000);
        check("mthi_after_rst_done", {63'd0, got_done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
- REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand width (valid values 8..64, even).
- REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning multiply latency in cycles (valid values 1..8).
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The block SHALL have port flush_i, input, 1 bit: pipeline flush; aborts any in-flight operation.
- REQ-006 The block SHALL have port op_valid_i, input, 1 bit: op_i is presented this cycle.
- REQ-007 The block SHALL have port op_i, input, mdu_op_t (3 bits): NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- REQ-008 The block SHALL have ports src_a and src_b, input, XLEN bits each: rs and rt operands.
- REQ-009 The block SHALL have port rd_hilo_i, input, 1 bit: the instruction now in execute reads HI or LO (MFHI/MFLO).
- REQ-010 The block SHALL have port hilo_o, output, 2*XLEN bits: architectural {HI, LO} register.
- REQ-011 The block SHALL have port busy_o, output, 1 bit: an operation is in flight.
- REQ-012 The block SHALL have port stall_o, output, 1 bit: the pipeline must hold the execute stage.
- REQ-013 The block SHALL have port done_o, output, 1 bit: one-cycle pulse on the cycle HI/LO is committed.

Function
- REQ-014 FSM states SHALL be IDLE, MUL, DIV and FIX; ops are accepted only in IDLE with op_valid_i=1, flush_i=0 and op_i≠NONE.
- REQ-015 MTHI/MTLO SHALL write HI=src_a / LO=src_a at the accepting edge, with the other half unchanged and done_o=0.
- REQ-016 MULT/MULTU (signed/unsigned 2*XLEN product, HI=upper) SHALL commit MUL_LAT edges after acceptance, with busy_o=1 for exactly MUL_LAT cycles.
- REQ-017 DIV/DIVU SHALL use restoring division, 1 quotient bit per cycle, on operand magnitudes: XLEN DIV cycles, then 1 FIX cycle for the sign (quotient sign = sign_a^sign_b, remainder sign = sign_a); LO=quotient, HI=remainder; busy_o=1 for exactly XLEN+1 cycles.
- REQ-018 A divide with src_b=0 SHALL skip iteration and commit HI=src_a, LO=all-ones after 1 cycle (busy_o=1 for 1 cycle).
- REQ-019 Signed MIN/-1 SHALL commit LO=MIN and HI=0.
- REQ-020 Commit SHALL happen on the edge where the FSM returns to IDLE; done_o=1 and the new hilo_o are visible in the first IDLE cycle.
- REQ-021 stall_o SHALL be busy_o & (rd_hilo_i | (op_valid_i & op_i≠NONE)) & ~flush_i.
- REQ-022 flush_i=1 SHALL return the FSM to IDLE at the next edge with no commit and HI/LO unchanged; flush_i wins over a simultaneous acceptance.
- REQ-023 flush_i asserted on a commit edge SHALL NOT suppress that commit.
- REQ-024 Operands SHALL be latched at acceptance; src_a and src_b are don't-care afterwards.

Reset
- REQ-025 rst SHALL force IDLE, hilo_o=0, busy_o=0, stall_o=0 and done_o=0 immediately, including mid-operation; no partial result is committed.

Structure
- REQ-026 Package mdu_pkg SHALL hold mdu_op_t, the FSM state enum and a default XLEN constant.
- REQ-027 The divider datapath and iteration counter SHALL be the sub-module mdu_div_iter; the multiplier SHALL be an inline MUL_LAT-deep register pipeline.

Verification (XLEN=32, MUL_LAT=3)
- REQ-028 MULT src_a=0xFFFFFFFF, src_b=2 -> busy_o 3 cycles, then hilo_o=0xFFFFFFFF_FFFFFFFE and done_o pulse; MULTU with the same operands -> 0x00000001_FFFFFFFE.
- REQ-029 DIV -7/2 -> busy_o 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- REQ-030 DIVU 5/0 -> 1 busy cycle, HI=5, LO=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- REQ-031 DIV in flight, rd_hilo_i=1 -> stall_o=1 until commit; flush_i at cycle 10 -> IDLE next cycle, hilo_o unchanged, no done_o.
- REQ-032 rst asserted mid-DIV -> all outputs 0 asynchronously; MTHI 0x1234 immediately after reset release -> hilo_o=0x00001234_00000000.
